receive_money_state_machine: RTL and testbench
==============================================

RECEIVE_MONEY_STATE_MACHINE -- requirements
Module: receive_money_state_machine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  begin a sale; sampled in IDLE only.
REQ-005 priceToPay  input  5  sale price in euros; bit 0 is ignored (forced even), giving a 0..30 range.
REQ-006 coin2Enters  input  1  one-cycle pulse, 2-euro coin inserted.
REQ-007 note10Enters  input  1  one-cycle pulse, 10-euro note inserted.
REQ-008 cancel  input  1  user abort; sampled in COLLECT only.
REQ-009 noMoneyLeft  input  1  dispenser completion pulse.
REQ-010 moneyToGive  output  5  amount the dispenser pays out; nonzero for exactly one cycle per transaction, otherwise 0.
REQ-011 amountInserted  output  5  running total inserted.
REQ-012 paid  output  1  one-cycle pulse when a sale completes.
REQ-013 refunded  output  1  one-cycle pulse when a sale is cancelled.
REQ-014 rejectMoney  output  1  one-cycle pulse when an insertion is refused.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 state  output  3  IDLE=0, COLLECT=1, CHANGE=2, REFUND=3, WAIT_DISPENSE=4; values 5-7 SHALL return to IDLE on the next edge.

Function
REQ-017 All outputs SHALL be registered; every input SHALL be sampled on the rising edge of clock.
REQ-018 IDLE: when start=1, the block SHALL latch {priceToPay[4:1],0}, clear amountInserted and enter COLLECT; otherwise it SHALL hold.
REQ-019 COLLECT, per edge: first note10Enters adds 10, then coin2Enters adds 2 to the updated total; any addition that would make the total exceed 30 SHALL be refused.
REQ-020 Simultaneous coin and note: each SHALL be accepted or refused independently, in the order note then coin.
REQ-021 rejectMoney SHALL pulse on the edge after a refused insertion, and also for any insertion pulse received outside COLLECT.
REQ-022 COLLECT: when the post-update total is >= the latched price and cancel=0, the next state SHALL be CHANGE.
REQ-023 COLLECT: cancel=1 SHALL go to REFUND, including when the same-edge insertion completes payment; that insertion is counted in the refund.
REQ-024 CHANGE (one cycle): moneyToGive = amountInserted - price, with the 5-bit result never negative; paid=1.
REQ-025 CHANGE exit: if the change is 0, go to IDLE; otherwise go to WAIT_DISPENSE.
REQ-026 REFUND (one cycle): moneyToGive = amountInserted; refunded=1.
REQ-027 REFUND exit: if the amount is 0, go to IDLE; otherwise go to WAIT_DISPENSE.
REQ-028 WAIT_DISPENSE SHALL hold moneyToGive=0 until noMoneyLeft=1, then clear amountInserted and go to IDLE.
REQ-029 start SHALL be ignored in every state except IDLE.
REQ-030 cancel SHALL be ignored in every state except COLLECT.
REQ-031 noMoneyLeft SHALL be ignored outside WAIT_DISPENSE.
REQ-032 A latched price of 0 SHALL pass through COLLECT for one cycle, then CHANGE with moneyToGive=0 and paid=1.

Reset
REQ-033 On reset the block SHALL enter IDLE and set moneyToGive=0, amountInserted=0, latched price=0, and paid=refunded=rejectMoney=0.
REQ-034 Reset mid-transaction SHALL abort the transaction with no refund, and any pending pulses SHALL be discarded.

Verification
REQ-035 Price 14, then note10 and two coin2 pulses -> amountInserted 10,12,14; CHANGE with moneyToGive=0 and paid=1; then IDLE.
REQ-036 Price 8, then one note10 -> CHANGE with moneyToGive=2 for one cycle and paid=1; WAIT_DISPENSE until a noMoneyLeft pulse; then IDLE with amountInserted=0.
REQ-037 Price 28, then three note10 pulses (the third arrives with total 20 -> 30) and then a further coin2 -> coin refused with rejectMoney pulse; a sale at total 30 gives moneyToGive=2.
REQ-038 Price 20, total 12, then cancel with a same-edge note10 -> REFUND with moneyToGive=22 and refunded=1; paid stays 0.
REQ-039 Price 4, with note10 and coin2 on the same edge -> total 12, CHANGE with moneyToGive=8.
REQ-040 Reset during WAIT_DISPENSE -> IDLE immediately with all outputs 0; a later noMoneyLeft has no effect.

Source files
------------

// File: rtl/receive_money_state_machine.sv
// Coin/note sale controller: latches an even price, collects 2- and 10-euro
// insertions up to 30, then issues change or a refund and waits for the dispenser.
module receive_money_state_machine (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] priceToPay,
  input  logic       coin2Enters,
  input  logic       note10Enters,
  input  logic       cancel,
  input  logic       noMoneyLeft,
  output logic [4:0] moneyToGive,
  output logic [4:0] amountInserted,
  output logic       paid,
  output logic       refunded,
  output logic       rejectMoney,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    COLLECT       = 3'd1,
    CHANGE        = 3'd2,
    REFUND        = 3'd3,
    WAIT_DISPENSE = 3'd4
  } state_t;

  state_t     st;
  logic [4:0] price;

  logic       note_ok;
  logic       coin_ok;
  logic       refuse;
  logic [4:0] after_note;
  logic [4:0] total;
  logic [4:0] change_amt;

  assign state = st;

  // Note is judged first, then the coin against the updated total; cap is 30.
  always_comb begin
    note_ok    = note10Enters && (amountInserted <= 5'd20);
    after_note = note_ok ? amountInserted + 5'd10 : amountInserted;
    coin_ok    = coin2Enters && (after_note <= 5'd28);
    total      = coin_ok ? after_note + 5'd2 : after_note;
    refuse     = (note10Enters && !note_ok) || (coin2Enters && !coin_ok);
    change_amt = (total >= price) ? total - price : 5'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st             <= IDLE;
      price          <= 5'd0;
      moneyToGive    <= 5'd0;
      amountInserted <= 5'd0;
      paid           <= 1'b0;
      refunded       <= 1'b0;
      rejectMoney    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      paid        <= 1'b0;
      refunded    <= 1'b0;
      rejectMoney <= 1'b0;
      moneyToGive <= 5'd0;
      case (st)
        IDLE: begin
          rejectMoney <= coin2Enters | note10Enters;
          if (start) begin
            price          <= priceToPay & 5'b11110;
            amountInserted <= 5'd0;
            st             <= COLLECT;
            busy           <= 1'b1;
          end
        end
        COLLECT: begin
          amountInserted <= total;
          rejectMoney    <= refuse;
          if (cancel) begin
            moneyToGive <= total;
            refunded    <= 1'b1;
            st          <= REFUND;
          end else if (total >= price) begin
            moneyToGive <= change_amt;
            paid        <= 1'b1;
            st          <= CHANGE;
          end
        end
        // moneyToGive still holds the payout issued on entry to these states.
        CHANGE, REFUND: begin
          rejectMoney <= coin2Enters | note10Enters;
          if (moneyToGive == 5'd0) begin
            st   <= IDLE;
            busy <= 1'b0;
          end else begin
            st <= WAIT_DISPENSE;
          end
        end
        WAIT_DISPENSE: begin
          rejectMoney <= coin2Enters | note10Enters;
          if (noMoneyLeft) begin
            amountInserted <= 5'd0;
            st             <= IDLE;
            busy           <= 1'b0;
          end
        end
        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receive_money_state_machine.sv
// Bench for receive_money_state_machine: directed sales plus random sales,
// payouts tracked through an expected queue of {refunded, moneyToGive}.
module tb_receive_money_state_machine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] priceToPay = 5'd0;
  logic       coin2Enters = 1'b0;
  logic       note10Enters = 1'b0;
  logic       cancel = 1'b0;
  logic       noMoneyLeft = 1'b0;
  logic [4:0] moneyToGive;
  logic [4:0] amountInserted;
  logic       paid;
  logic       refunded;
  logic       rejectMoney;
  logic       busy;
  logic [2:0] state;

  int total_cnt = 0;
  int bad_cnt = 0;
  logic [5:0] exp_q[$];

  receive_money_state_machine dut (
    .clock(clock), .reset(reset), .start(start), .priceToPay(priceToPay),
    .coin2Enters(coin2Enters), .note10Enters(note10Enters), .cancel(cancel),
    .noMoneyLeft(noMoneyLeft), .moneyToGive(moneyToGive),
    .amountInserted(amountInserted), .paid(paid), .refunded(refunded),
    .rejectMoney(rejectMoney), .busy(busy), .state(state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver: called at a falling edge, applies inputs for exactly one rising edge.
  task automatic step(input logic s, input logic [4:0] p, input logic n,
                      input logic c, input logic x, input logic m);
    start = s; priceToPay = p; note10Enters = n; coin2Enters = c;
    cancel = x; noMoneyLeft = m;
    @(posedge clock);
    #1;
    start = 1'b0; note10Enters = 1'b0; coin2Enters = 1'b0;
    cancel = 1'b0; noMoneyLeft = 1'b0;
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Scoreboard: every paid/refunded pulse consumes one expected payout.
  always @(negedge clock) begin
    if (paid || refunded) begin
      if (exp_q.size() == 0) begin
        check("unexpected_payout", int'({refunded, moneyToGive}), -1);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        check("payout", int'({refunded, moneyToGive}), int'(e));
        check("paid_excl", int'(paid & refunded), 0);
      end
    end else if (moneyToGive != 5'd0) begin
      check("stray_money", int'(moneyToGive), 0);
    end
  end

  initial begin
    int p, t, k;
    logic n, c, x, rej, done;

    repeat (3) @(negedge clock);
    check("rst_state", int'(state), 0);
    check("rst_money", int'(moneyToGive), 0);
    check("rst_amount", int'(amountInserted), 0);
    check("rst_pulses", int'({paid, refunded, rejectMoney, busy}), 0);
    reset = 1'b0;
    @(negedge clock);

    // Insertion and cancel outside COLLECT
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("idle_coin_rej", int'(rejectMoney), 1);
    check("idle_cancel_state", int'(state), 0);

    // Price 14: 10, 12, 14 -> exact payment
    step(1'b1, 5'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    check("p14_state", int'(state), 1);
    check("p14_busy", int'(busy), 1);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p14_amt10", int'(amountInserted), 10);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p14_amt12", int'(amountInserted), 12);
    exp_q.push_back({1'b0, 5'd0});
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p14_amt14", int'(amountInserted), 14);
    check("p14_change", int'(state), 2);
    check("p14_paid", int'(paid), 1);
    idle();
    check("p14_idle", int'(state), 0);
    check("p14_busy_lo", int'(busy), 0);

    // Price 8: one note, change 2, wait for dispenser
    step(1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 5'd2});
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p8_change", int'(state), 2);
    idle();
    check("p8_wait", int'(state), 4);
    step(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("p8_wait_hold", int'(state), 4);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p8_idle", int'(state), 0);
    check("p8_amt_clr", int'(amountInserted), 0);

    // Price 28: third note with coin on the same edge -> coin refused
    step(1'b1, 5'd28, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 5'd2});
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("p28_amt30", int'(amountInserted), 30);
    check("p28_rej", int'(rejectMoney), 1);
    check("p28_change", int'(state), 2);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("p28_change_coin_rej", int'(rejectMoney), 1);
    check("p28_wait", int'(state), 4);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p28_idle", int'(state), 0);

    // Price 30: note at 22 refused, then coins up to 30
    step(1'b1, 5'd30, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p30_note_rej", int'(rejectMoney), 1);
    check("p30_amt22", int'(amountInserted), 22);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({1'b0, 5'd0});
      step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("p30_amt30", int'(amountInserted), 30);
    check("p30_change", int'(state), 2);
    idle();

    // Price 20: cancel with same-edge note -> refund 22
    step(1'b1, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 5'd22});
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("p20_refund", int'(state), 3);
    check("p20_paid_lo", int'(paid), 0);
    idle();
    check("p20_wait", int'(state), 4);
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p20_idle", int'(state), 0);

    // Price 4: note and coin together -> 12, change 8
    step(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 5'd8});
    step(1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("p4_amt12", int'(amountInserted), 12);
    check("p4_rej_lo", int'(rejectMoney), 0);
    idle();
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("p4_idle", int'(state), 0);

    // Price 1 reads as 0: one COLLECT cycle then CHANGE with 0
    step(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("p0_collect", int'(state), 1);
    exp_q.push_back({1'b0, 5'd0});
    idle();
    check("p0_change", int'(state), 2);
    idle();
    check("p0_idle", int'(state), 0);

    // Cancel with nothing inserted -> zero refund, straight to IDLE
    step(1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 5'd0});
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("r0_refund", int'(state), 3);
    idle();
    check("r0_idle", int'(state), 0);

    // Reset during WAIT_DISPENSE
    step(1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 5'd2});
    step(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check("rw_wait", int'(state), 4);
    reset = 1'b1;
    #1;
    check("rw_state", int'(state), 0);
    check("rw_outs", int'({moneyToGive, amountInserted, paid, refunded, rejectMoney, busy}), 0);
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rw_nml_state", int'(state), 0);
    check("rw_nml_money", int'(moneyToGive), 0);

    // Random sales against a small reference model
    for (int s = 0; s < 25; s++) begin
      p = int'($urandom_range(0, 31));
      step(1'b1, 5'(p), 1'b0, 1'b0, 1'b0, 1'b0);
      p = p & 30;
      t = 0;
      done = 1'b0;
      k = 0;
      while (!done && k < 40) begin
        n = 1'($urandom_range(0, 1));
        c = 1'($urandom_range(0, 1));
        x = (k == 39) || ($urandom_range(0, 11) == 0);
        rej = 1'b0;
        if (n) begin
          if (t + 10 <= 30) t += 10; else rej = 1'b1;
        end
        if (c) begin
          if (t + 2 <= 30) t += 2; else rej = 1'b1;
        end
        if (x) begin
          exp_q.push_back({1'b1, 5'(t)});
          done = 1'b1;
        end else if (t >= p) begin
          exp_q.push_back({1'b0, 5'(t - p)});
          done = 1'b1;
        end
        step(1'b0, 5'd0, n, c, x, 1'b0);
        check("rnd_amt", int'(amountInserted), t);
        check("rnd_rej", int'(rejectMoney), int'(rej));
        k++;
      end
      check("rnd_state", int'(state), x ? 3 : 2);
      if (x) k = t; else k = t - p;
      idle();
      check("rnd_exit", int'(state), (k == 0) ? 0 : 4);
      if (k != 0) begin
        step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rnd_idle", int'(state), 0);
      end
    end

    idle();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
